// File: rtl/auto_play_seq.sv
// auto_play_seq: auto-play playback sequencer.
// When start is pulsed, the sequencer latches a song index. It walks that song's
// note table in the shared score ROM through a req/ack fetch and drives note codes
// to the tone generator with beat-accurate timing. dbg_state exposes the FSM state.
// Optional build macro AUTO_PLAY_LOOP_EN: the song repeats from its first entry
// instead of ending; done pulses once per pass and only stop or reset exits.
//
// ROM handshake: rom_req is high for exactly the cycles spent in FETCH.
// rom_addr is stable while rom_req is high. The ROM answers with a
// single-cycle rom_ack that carries rom_data in the same cycle. A transfer
// takes place on the clock edge that sees rom_req && rom_ack. An ack that
// arrives outside FETCH, such as after stop, is ignored.
module auto_play_seq #(
  parameter int SONG_W     = 2,
  parameter int NOTE_AW    = 6,
  parameter int BEAT_TICKS = 25_000_000,
  parameter int GAP_TICKS  = 2_500_000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic                      start,
  input  logic                      stop,
  input  logic [7:0]                song_index,
  output logic                      rom_req,
  output logic [SONG_W+NOTE_AW-1:0] rom_addr,
  input  logic                      rom_ack,
  input  logic [9:0]                rom_data,
  output logic [5:0]                note_code,
  output logic                      playing,
  output logic                      done,
  output logic [2:0]                dbg_state
);

  localparam int TICK_W = (BEAT_TICKS > 2) ? $clog2(BEAT_TICKS) : 1;
  // The tick counter spans a whole beat. In the final beat, the sound phase ends
  // at SOUND_LAST and the remaining ticks form the silent gap.
  localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(BEAT_TICKS - 1);
  localparam logic [TICK_W-1:0]  SOUND_LAST = TICK_W'(BEAT_TICKS - GAP_TICKS - 1);
  localparam logic [NOTE_AW-1:0] PTR_LAST   = {NOTE_AW{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_SOUND = 3'd2,
    S_GAP   = 3'd3,
    S_END   = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [SONG_W-1:0]   song_q,  song_d;
  logic [NOTE_AW-1:0]  ptr_q,   ptr_d;
  logic [5:0]          note_q,  note_d;
  logic [3:0]          beat_q,  beat_d;
  logic [TICK_W-1:0]   tick_q,  tick_d;

  logic unused_song_bits;
  assign unused_song_bits = ^song_index[7:SONG_W];

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      song_q  <= '0;
      ptr_q   <= '0;
      note_q  <= '0;
      beat_q  <= '0;
      tick_q  <= '0;
    end else begin
      state_q <= state_d;
      song_q  <= song_d;
      ptr_q   <= ptr_d;
      note_q  <= note_d;
      beat_q  <= beat_d;
      tick_q  <= tick_d;
    end
  end

  // Next-state logic. stop beats start. The pause freezes everything
  // except the acceptance of an outstanding ROM ack.
  always_comb begin
    state_d = state_q;
    song_d  = song_q;
    ptr_d   = ptr_q;
    note_d  = note_q;
    beat_d  = beat_q;
    tick_d  = tick_q;
    if (stop) begin
      if (state_q != S_IDLE) begin
        state_d = S_IDLE;
        note_d  = '0;
      end
    end else if (start) begin
      song_d  = song_index[SONG_W-1:0];
      ptr_d   = '0;
      note_d  = '0;
      state_d = S_FETCH;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (rom_ack) begin
            if (rom_data[3:0] == 4'd0) begin
              state_d = S_END;
            end else begin
              note_d  = rom_data[9:4];
              beat_d  = rom_data[3:0];
              tick_d  = '0;
              state_d = S_SOUND;
            end
          end
        end
        S_SOUND: begin
          if (enable) begin
            if (beat_q == 4'd1 && tick_q == SOUND_LAST) begin
              note_d  = '0;
              tick_d  = tick_q + 1'b1;
              state_d = S_GAP;
            end else if (tick_q == TICK_LAST) begin
              tick_d = '0;
              beat_d = beat_q - 4'd1;
            end else begin
              tick_d = tick_q + 1'b1;
            end
          end
        end
        S_GAP: begin
          if (enable) begin
            if (tick_q == TICK_LAST) begin
              if (ptr_q == PTR_LAST) begin
                state_d = S_END;
              end else begin
                ptr_d   = ptr_q + 1'b1;
                state_d = S_FETCH;
              end
            end else begin
              tick_d = tick_q + 1'b1;
            end
          end
        end
        S_END: begin
          if (enable) begin
`ifdef AUTO_PLAY_LOOP_EN
            ptr_d   = '0;
            state_d = S_FETCH;
`else
            state_d = S_IDLE;
`endif
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Outputs are decoded from the registered state. The pause silences the note.
  always_comb begin
    rom_req   = (state_q == S_FETCH);
    rom_addr  = {song_q, ptr_q};
    note_code = (state_q == S_SOUND && enable) ? note_q : 6'd0;
    done      = (state_q == S_END) && enable;
`ifdef AUTO_PLAY_LOOP_EN
    playing   = (state_q != S_IDLE);
`else
    playing   = (state_q == S_FETCH) || (state_q == S_SOUND) || (state_q == S_GAP);
`endif
    dbg_state = state_q;
  end

endmodule

// File: tb/tb_auto_play_seq.sv
// tb_auto_play_seq: directed bench for auto_play_seq (BEAT_TICKS=4, GAP_TICKS=1).
module tb_auto_play_seq;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_SOUND = 3'd2;
`ifdef AUTO_PLAY_LOOP_EN
  localparam logic LOOP = 1'b1;
`else
  localparam logic LOOP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [7:0] song_index = 8'd0;
  logic       rom_req;
  logic [7:0] rom_addr;
  logic       rom_ack = 1'b0;
  logic [9:0] rom_data = 10'd0;
  logic [5:0] note_code;
  logic       playing;
  logic       done;
  logic [2:0] dbg_state;

  logic [9:0] rom_mem [0:255];
  int         ack_delay = 1;
  int         wait_cnt = 0;
  int         n_tests = 0;
  int         n_fail = 0;

  typedef struct {
    logic       start;
    logic [7:0] idx;
    logic       req;
    logic [7:0] addr;
    logic [5:0] note;
    logic       play;
    logic       done;
  } vec_t;
  vec_t vec_q[$];

  auto_play_seq #(
    .SONG_W(2), .NOTE_AW(6), .BEAT_TICKS(4), .GAP_TICKS(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .start(start), .stop(stop),
    .song_index(song_index), .rom_req(rom_req), .rom_addr(rom_addr),
    .rom_ack(rom_ack), .rom_data(rom_data), .note_code(note_code),
    .playing(playing), .done(done), .dbg_state(dbg_state)
  );

  // Clock block
  always #5 clk = ~clk;

  // ROM model: answers ack_delay cycles after it first sees rom_req
  always @(negedge clk) begin
    if (rom_req && !rom_ack) begin
      if (wait_cnt >= ack_delay) begin
        rom_ack  = 1'b1;
        rom_data = rom_mem[rom_addr];
        wait_cnt = 0;
      end else begin
        wait_cnt++;
      end
    end else begin
      rom_ack  = 1'b0;
      wait_cnt = 0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [7:0] idx);
    song_index = idx;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    step();
    stop = 1'b0;
    step();
  endtask

  task automatic wait_note(input logic [5:0] n, input int budget, input string name);
    int c;
    c = 0;
    while (note_code !== n && c < budget) begin
      step();
      c++;
    end
    check(name, note_code, n);
  endtask

  task automatic add_vec(input logic s, input logic [7:0] idx, input logic req,
                         input logic [7:0] addr, input logic [5:0] note,
                         input logic play, input logic dn);
    vec_t v;
    v.start = s; v.idx = idx; v.req = req; v.addr = addr;
    v.note = note; v.play = play; v.done = dn;
    vec_q.push_back(v);
  endtask

  initial begin
    int    cyc;
    int    first_note;
    int    done_cyc;
    int    fetch_cnt;
    int    cnt;
    logic  bad;
    logic  base_bad;
    logic  prev_req;
    logic [7:0] prev_addr;

    for (int i = 0; i < 256; i++) rom_mem[i] = 10'd0;
    rom_mem[8'h40] = {6'h1A, 4'd2};
    rom_mem[8'h41] = {6'h05, 4'd1};
    rom_mem[8'h42] = 10'd0;
    for (int i = 0; i < 64; i++) rom_mem[8'h80 + i] = {6'(i + 1), 4'd1};

    // Test 1 vectors, one row per clock edge after start (song_index changes to 3 after the start edge)
    add_vec(1, 8'd1, 1, 8'h40, 6'h00, 1, 0);
    add_vec(0, 8'd3, 1, 8'h40, 6'h00, 1, 0);
    for (int i = 0; i < 7; i++) add_vec(0, 8'd3, 0, 8'h40, 6'h1A, 1, 0);
    add_vec(0, 8'd3, 0, 8'h40, 6'h00, 1, 0);
    add_vec(0, 8'd3, 1, 8'h41, 6'h00, 1, 0);
    add_vec(0, 8'd3, 1, 8'h41, 6'h00, 1, 0);
    for (int i = 0; i < 3; i++) add_vec(0, 8'd3, 0, 8'h41, 6'h05, 1, 0);
    add_vec(0, 8'd3, 0, 8'h41, 6'h00, 1, 0);
    add_vec(0, 8'd3, 1, 8'h42, 6'h00, 1, 0);
    add_vec(0, 8'd3, 1, 8'h42, 6'h00, 1, 0);
    add_vec(0, 8'd3, 0, 8'h42, 6'h00, LOOP, 1);
    add_vec(0, 8'd3, LOOP, LOOP ? 8'h40 : 8'h42, 6'h00, LOOP, 0);

    // Reset block
    repeat (3) @(posedge clk);
    #1;
    check("rst_req", rom_req, 0);
    check("rst_addr", rom_addr, 0);
    check("rst_note", note_code, 0);
    check("rst_playing", playing, 0);
    check("rst_done", done, 0);
    check("rst_state", dbg_state, ST_IDLE);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Test 1: full song, table-driven
    foreach (vec_q[i]) begin
      start = vec_q[i].start;
      song_index = vec_q[i].idx;
      step();
      check($sformatf("t1_req[%0d]", i), rom_req, vec_q[i].req);
      check($sformatf("t1_addr[%0d]", i), rom_addr, vec_q[i].addr);
      check($sformatf("t1_note[%0d]", i), note_code, vec_q[i].note);
      check($sformatf("t1_playing[%0d]", i), playing, vec_q[i].play);
      check($sformatf("t1_done[%0d]", i), done, vec_q[i].done);
    end
    start = 1'b0;
`ifdef AUTO_PLAY_LOOP_EN
    // Test 6: the second pass ends with another done pulse, and play continues
    cnt = 0;
    while (done !== 1'b1 && cnt < 40) begin
      step();
      cnt++;
    end
    check("t6_done_again", done, 1);
    check("t6_playing_held", playing, 1);
    pulse_stop();
    check("t6_stop_playing", playing, 0);
    check("t6_stop_state", dbg_state, ST_IDLE);
`else
    step();
    check("t1_idle_after", dbg_state, ST_IDLE);
`endif

    // Test 2: stop in SOUND
    pulse_start(8'd1);
    wait_note(6'h1A, 20, "t2_note_seen");
    step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("t2_note", note_code, 0);
    check("t2_playing", playing, 0);
    check("t2_req", rom_req, 0);
    check("t2_state", dbg_state, ST_IDLE);
    bad = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (done !== 1'b0 || dbg_state !== ST_IDLE) bad = 1'b1;
    end
    check("t2_no_done", bad, 0);

    // Test 2b: stop while an ack is being presented, ack ignored
    pulse_start(8'd1);
    step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("t2b_state", dbg_state, ST_IDLE);
    step();
    check("t2b_stays_idle", dbg_state, ST_IDLE);
    check("t2b_note", note_code, 0);

    // Test 3: start and stop together in IDLE
    start = 1'b1;
    stop = 1'b1;
    song_index = 8'd1;
    step();
    start = 1'b0;
    stop = 1'b0;
    check("t3_state", dbg_state, ST_IDLE);
    check("t3_playing", playing, 0);
    check("t3_req", rom_req, 0);

    // Test 4: 10-cycle pause mid-note
    pulse_start(8'd1);
    wait_note(6'h1A, 20, "t4_note_seen");
    cnt = 1;
    for (int i = 0; i < 2; i++) begin
      step();
      if (note_code === 6'h1A) cnt++;
    end
    enable = 1'b0;
    #1;
    bad = (note_code !== 6'h00) || (dbg_state !== ST_SOUND);
    for (int i = 0; i < 10; i++) begin
      step();
      if (note_code !== 6'h00 || dbg_state !== ST_SOUND) bad = 1'b1;
    end
    check("t4_pause_silent_frozen", bad, 0);
    enable = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      if (note_code === 6'h1A) cnt++;
    end
    check("t4_total_sound", cnt, 7);
    pulse_stop();

    // Test 4b: ack taken while paused in FETCH; the note sounds on resume
    pulse_start(8'd1);
    enable = 1'b0;
    step();
    step();
    check("t4b_state", dbg_state, ST_SOUND);
    check("t4b_note_paused", note_code, 0);
    enable = 1'b1;
    #1;
    check("t4b_note_resumed", note_code, 6'h1A);
    pulse_stop();

    // Restart while playing: the new index is latched and the pointer is reset
    pulse_start(8'd1);
    wait_note(6'h1A, 20, "rs_note_seen");
    pulse_start(8'd2);
    check("rs_state", dbg_state, ST_FETCH);
    check("rs_addr", rom_addr, 8'h80);
    check("rs_note", note_code, 0);
    check("rs_playing", playing, 1);
    pulse_stop();

    // Test 5: 64-entry table, ack delayed 5 cycles, pointer end without a marker
    ack_delay = 5;
    pulse_start(8'h06);
    cyc = 0;
    first_note = -1;
    done_cyc = -1;
    fetch_cnt = 1;
    bad = 1'b0;
    base_bad = 1'b0;
    prev_req = rom_req;
    prev_addr = rom_addr;
    while (done_cyc < 0 && cyc < 800) begin
      step();
      cyc++;
      if (first_note < 0 && note_code !== 6'h00) first_note = cyc;
      if (rom_req && prev_req && rom_addr !== prev_addr) bad = 1'b1;
      if (rom_req && !prev_req) fetch_cnt++;
      if (rom_addr[7:6] !== 2'b10) base_bad = 1'b1;
      if (done === 1'b1) done_cyc = cyc;
      prev_req = rom_req;
      prev_addr = rom_addr;
    end
    check("t5_first_note_cycle", first_note, 6);
    check("t5_addr_stable", bad, 0);
    check("t5_addr_in_base", base_bad, 0);
    check("t5_fetch_count", fetch_cnt, 64);
    check("t5_done_cycle", done_cyc, 640);
    check("t5_last_addr", rom_addr, 8'hBF);
    pulse_stop();
    ack_delay = 1;

    // Asynchronous reset in the middle of a note
    pulse_start(8'd1);
    wait_note(6'h1A, 20, "ar_note_seen");
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_note", note_code, 0);
    check("ar_playing", playing, 0);
    check("ar_addr", rom_addr, 0);
    check("ar_state", dbg_state, ST_IDLE);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("ar_stays_idle", dbg_state, ST_IDLE);

    // Final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
